// File: rtl/key_event_pkg.sv
// Shared types for the front-panel key event path.
package key_event_pkg;

    localparam int unsigned NUM_KEYS = 8;
    localparam int unsigned KEY_W    = 3;

    typedef struct packed {
        logic             press;
        logic [KEY_W-1:0] key;
    } key_event_t;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer plus stability counter producing a debounced level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic level,
    output logic change_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    // Fires on the edge where the count would reach DEBOUNCE_CYCLES.
    assign change_c = (sync_q2 != level) && (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (change_c) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Debounces eight panel keys and queues press/release events in a FWFT FIFO.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [KEY_W-1:0]    ev_key,
    output logic                ev_press,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] toggles,
    output logic                overflow,
    input  logic                clear_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [NUM_KEYS-1:0] change_c;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] ptype;
    logic [NUM_KEYS-1:0] pending_nx;
    logic [NUM_KEYS-1:0] ptype_nx;
    logic [NUM_KEYS-1:0] toggles_nx;
    logic                lost_c;
    logic                any_pending_c;
    logic                push_c;
    logic                pop_c;
    logic                full_c;
    logic                empty_c;
    logic [KEY_W-1:0]    push_idx;
    key_event_t          push_data;
    key_event_t          head;

    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    key_event_t          mem [FIFO_DEPTH];

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock    (clock),
            .reset    (reset),
            .key_raw  (keys_raw[k]),
            .level    (key_state[k]),
            .change_c (change_c[k])
        );
    end

    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_c   = !empty_c && ev_ready;

    // Lowest-index pending arbiter plus pending/type/toggle bookkeeping.
    always_comb begin
        any_pending_c = 1'b0;
        push_idx      = '0;
        push_c        = 1'b0;
        pending_nx    = pending;
        ptype_nx      = ptype;
        toggles_nx    = toggles;
        lost_c        = 1'b0;

        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                any_pending_c = 1'b1;
                push_idx      = KEY_W'(k);
            end
        end
        push_c = any_pending_c && !full_c;
        if (push_c) begin
            pending_nx[push_idx] = 1'b0;
        end

        for (int k = 0; k < NUM_KEYS; k++) begin
            if (change_c[k]) begin
                // An event leaving this cycle is not lost; only an unsent one is.
                if (pending[k] && !(push_c && (push_idx == KEY_W'(k)))) begin
                    lost_c = 1'b1;
                end
                pending_nx[k] = 1'b1;
                ptype_nx[k]   = ~key_state[k];
                if (!key_state[k]) begin
                    toggles_nx[k] = ~toggles[k];
                end
            end
        end
    end

    assign push_data.press = ptype[push_idx];
    assign push_data.key   = push_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            pending  <= '0;
            ptype    <= '0;
            toggles  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pending <= pending_nx;
            ptype   <= ptype_nx;
            toggles <= toggles_nx;
            if (clear_overflow) begin
                overflow <= 1'b0;
            end else if (lost_c) begin
                overflow <= 1'b1;
            end
            if (push_c) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign ev_valid = !empty_c;
    assign ev_key   = head.key;
    assign ev_press = head.press;

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles needed to accept a key level change (min 1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, event queue entries; power of two, min 2.
REQ-003 SHALL have port clock  input  1  system clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high; clock clock.
REQ-005 SHALL have port keys_raw  input  8  TM1638 key levels from the front-panel driver's keys output, 1 = pressed.
REQ-006 SHALL have port ev_valid  output  1  queue head holds an event.
REQ-007 SHALL have port ev_ready  input  1  consumer accepts head event.
REQ-008 SHALL have port ev_key  output  3  key index of head event.
REQ-009 SHALL have port ev_press  output  1  head event type: 1 = press, 0 = release.
REQ-010 SHALL have port key_state  output  8  debounced key levels.
REQ-011 SHALL have port toggles  output  8  per-key toggle bits, for direct use as the LED input.
REQ-012 SHALL have port overflow  output  1  sticky: an event was lost.
REQ-013 SHALL have port clear_overflow  input  1  clears overflow.

Function
REQ-014 SHALL pass each keys_raw bit through a 2-flop synchronizer.
REQ-015 SHALL keep one counter per key: reset to 0 when the synced bit equals key_state[k]; otherwise increment.
REQ-016 SHALL, on the edge where the counter reaches DEBOUNCE_CYCLES, invert key_state[k] and zero the counter. Glitches shorter than DEBOUNCE_CYCLES never change key_state.
REQ-017 SHALL, on the same edge as a key_state[k] change, set pending[k] = 1 and ptype[k] = new level.
REQ-018 SHALL, if pending[k] is already set when a new change occurs, overwrite ptype[k] and set overflow.
REQ-019 SHALL flip toggles[k] on the edge where key_state[k] goes 0->1. Releases do not affect toggles.
REQ-020 SHALL, each cycle when not full, push {ptype, k} for the lowest-index pending k and clear that pending bit. At most one push per cycle.
REQ-021 SHALL keep pending bits while full. Pending events are not dropped; loss occurs only per REQ-018.
REQ-022 SHALL evaluate full before any same-cycle pop: no push when full, even if popping.
REQ-023 SHALL use a first-word-fall-through queue. ev_valid = not empty. ev_key/ev_press reflect head. Pop iff ev_valid & ev_ready. ev_ready while empty is ignored.
REQ-024 SHALL keep the head stable while ev_valid & !ev_ready.
REQ-025 SHALL, with an empty queue and no pending events, raise ev_valid exactly DEBOUNCE_CYCLES+3 cycles after the first clock edge sampling the new keys_raw level: 2 sync, DEBOUNCE_CYCLES count, 1 push.
REQ-026 SHALL wrap pointers modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
REQ-027 SHALL clear overflow on clear_overflow. Clear wins over a same-cycle set.

Reset
REQ-028 SHALL, on reset, zero synchronizers, counters, key_state, toggles, pending, ptype and overflow, and empty the queue (ev_valid = 0, ev_key = 0, ev_press = 0).
REQ-029 SHALL let reset mid-debounce or mid-queue discard all state. A key held through reset generates a press event DEBOUNCE_CYCLES+3 cycles after reset deasserts.

Structure
REQ-030 SHALL place NUM_KEYS = 8 and typedef key_event_t {press, key[2:0]} in shared package key_event_pkg.
REQ-031 SHALL implement synchronizer, counter and key_state in sub-module key_debounce, instantiated 8 times via generate. Arbiter and queue live in key_event_queue.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-032 SHALL test: keys_raw[2] 0->1 held, ev_ready=1 -> key_state=8'h04, toggles=8'h04, one event {key=2, press=1} with ev_valid 7 cycles after sampling.
REQ-033 SHALL test: keys_raw[5] pulses high 3 cycles -> no event, key_state stays 8'h00.
REQ-034 SHALL test: keys_raw 8'h00->8'h81 same cycle -> events key=0 then key=7, both press, on consecutive cycles.
REQ-035 SHALL test: ev_ready=0, 6 press/release events (keys 0..2) -> queue holds 4, 2 pending. Raise ev_ready -> all 6 delivered in order, overflow=0.
REQ-036 SHALL test: ev_ready=0, key 1 changes while its event is pending and the queue is full -> overflow=1. clear_overflow pulse -> overflow=0.
REQ-037 SHALL test: reset asserted with 3 queued events and key 4 held -> ev_valid=0 next cycle. After release, {key=4, press=1} appears 7 cycles later.
